// File: rtl/acc_nibble_seq_pkg.sv
// Shared types and helpers for the nibble-serial accumulator.
package acc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nib_of(input int w);
    return w / NIB_W;
  endfunction
endpackage

// File: rtl/acc_nibble_seq_ffulladd.sv
// 4-bit carry-lookahead adder shared by the accumulator datapath.
module ffulladd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // carries expanded from generate/propagate so no ripple through the nibble
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/acc_nibble_seq.sv
// Accumulator that adds each accepted operand one nibble per cycle via ffulladd.
// Optional ACC_SUB_EN adds an in_sub port selecting two's-complement subtraction.
module acc_nibble_seq
  import acc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
`ifdef ACC_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = nib_of(ACC_W);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [ACC_W-1:0] work, opnd, work_nx;
  logic [CW-1:0]    cnt;
  logic             cy, sub, vld_q;
  logic [3:0]       add_b, add_s;
  logic             add_co;

`ifdef ACC_SUB_EN
  assign add_b = sub ? ~opnd[3:0] : opnd[3:0];
`else
  assign add_b = opnd[3:0];
`endif

  ffulladd u_add (
    .a    (work[3:0]),
    .b    (add_b),
    .cin  (cy),
    .s    (add_s),
    .cout (add_co)
  );

  // work rotates right a nibble, the fresh sum nibble entering at the top
  assign work_nx = (work >> NIB_W) | (ACC_W'(add_s) << (ACC_W - NIB_W));

  // clr in DONE must kill the pulse that is already showing
  assign acc_valid = vld_q & ~clr;
  assign busy      = ~in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc_out  <= '0;
      ovf      <= 1'b0;
      vld_q    <= 1'b0;
      in_ready <= 1'b1;
      work     <= '0;
      opnd     <= '0;
      cnt      <= '0;
      cy       <= 1'b0;
      sub      <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      acc_out  <= '0;
      ovf      <= 1'b0;
      vld_q    <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          vld_q <= 1'b0;
          if (in_valid) begin
            opnd     <= in_data;
            work     <= acc_out;
            cnt      <= '0;
`ifdef ACC_SUB_EN
            sub      <= in_sub;
            cy       <= in_sub;
`else
            sub      <= 1'b0;
            cy       <= 1'b0;
`endif
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          work <= work_nx;
          opnd <= opnd >> NIB_W;
          cy   <= add_co;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(NIB - 1)) begin
            acc_out <= work_nx;
            // subtraction overflows on borrow, i.e. no final carry
            ovf     <= ovf | (sub ? ~add_co : add_co);
            vld_q   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          vld_q    <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          vld_q    <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_acc_nibble_seq.sv
// Directed plus random bench for acc_nibble_seq against an arithmetic reference.
module tb_acc_nibble_seq;
  localparam int ACC_W = 16;
  localparam int NIB   = ACC_W / 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, clr, in_sub;
  logic [ACC_W-1:0] in_data;
  logic             in_ready, acc_valid, ovf, busy;
  logic [ACC_W-1:0] acc_out;

  int errors = 0;
  int checks = 0;

  logic [ACC_W-1:0] m_acc;
  logic             m_ovf;

  acc_nibble_seq #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef ACC_SUB_EN
    .in_sub    (in_sub),
`endif
    .clr       (clr),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic model_op(input logic [ACC_W-1:0] d, input bit s);
    logic [ACC_W:0] r;
    if (s) begin
      r     = {1'b0, m_acc} - {1'b0, d};
      m_ovf = m_ovf | (d > m_acc);
    end else begin
      r     = {1'b0, m_acc} + {1'b0, d};
      m_ovf = m_ovf | r[ACC_W];
    end
    m_acc = r[ACC_W-1:0];
  endtask

  // called at a negedge; returns at a negedge with the block idle again
  task automatic op(input logic [ACC_W-1:0] d, input bit s, input bit hold);
    int lat;
    bit stable;
    lat = 0;
    stable = 1'b1;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = ACC_W'($urandom);
      in_sub   = 1'($urandom);
    end
    while (acc_valid !== 1'b1 && lat < 20) begin
      if (acc_out !== m_acc) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    model_op(d, s);
    check("latency", 32'(lat), 32'(NIB + 1));
    check("acc_stable", 32'(stable), 32'd1);
    check("acc_out", 32'(acc_out), 32'(m_acc));
    check("ovf", 32'(ovf), 32'(m_ovf));
    @(negedge clk);
    check("pulse_one_cycle", 32'(acc_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; in_sub = 1'b0; in_data = '0;
    m_acc = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_acc", 32'(acc_out), 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(acc_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    op(16'h1234, 1'b0, 1'b0);
    check("add_1234", 32'(acc_out), 32'h1234);
    op(16'h0FFF, 1'b0, 1'b0);
    check("add_0fff", 32'(acc_out), 32'h2233);

    pulse_clr();
    op(16'h00FF, 1'b0, 1'b0);
    op(16'h0001, 1'b0, 1'b0);
    check("nib_carry", 32'(acc_out), 32'h0100);
    check("nib_carry_ovf", 32'(ovf), 32'd0);

    pulse_clr();
    op(16'hFFFF, 1'b0, 1'b0);
    op(16'h0002, 1'b0, 1'b0);
    check("ovf_wrap", 32'(acc_out), 32'h0001);
    check("ovf_set", 32'(ovf), 32'd1);
    op(16'h0001, 1'b0, 1'b0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    pulse_clr();
    check("clr_acc", 32'(acc_out), 32'h0);
    check("clr_ovf", 32'(ovf), 32'd0);

    // abort: clr two cycles after the accept edge
    op(16'h0300, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'h1111; in_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_acc", 32'(acc_out), 32'h0);
    pulses = 0;
    repeat (8) begin
      if (acc_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    // backpressure: in_valid held through the whole operation
    op(16'h0005, 1'b0, 1'b1);
    pulses = 0;
    repeat (8) begin
      if (acc_valid === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    check("hold_single_accept", 32'(pulses), 32'd0);
    check("hold_acc", 32'(acc_out), 32'h0005);

`ifdef ACC_SUB_EN
    pulse_clr();
    op(16'h0010, 1'b0, 1'b0);
    op(16'h0001, 1'b1, 1'b0);
    check("sub_small", 32'(acc_out), 32'h000F);
    check("sub_small_ovf", 32'(ovf), 32'd0);
    op(16'h0020, 1'b1, 1'b0);
    check("sub_borrow", 32'(acc_out), 32'hFFEF);
    check("sub_borrow_ovf", 32'(ovf), 32'd1);
`endif

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_clr();
`ifdef ACC_SUB_EN
      op(ACC_W'($urandom), 1'($urandom), 1'($urandom));
`else
      op(ACC_W'($urandom), 1'b0, 1'($urandom));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
